// File: rtl/irrigation_event_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_event_sequencer
//
// Requests samples of the four sensor threshold bits on a fixed tick and
// captures them when the sensor front-end acknowledges. An irrigation event
// is two or more sensor bits set in a sample. After CONFIRM_N consecutive
// event samples the valve is opened. It stays open for at least MIN_ON
// cycles and at most MAX_ON cycles. A COOLDOWN hold follows. A watchdog
// faults the block if the sensor front-end never acknowledges a request.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   system enable
//   sensor_bits   in   [3] air temp, [2] soil temp, [1] air humidity,
//                      [0] soil moisture
//   sensor_valid  in   front-end ack, sensor_bits valid while high
//   fault_clear   in   one-cycle pulse, leaves FAULT
//   sample_req    out  sample request to the front-end
//   valve_on      out  valve drive
//   event_flag    out  popcount(last sample) >= 2
//   any_flag      out  any bit set in last sample
//   active_count  out  popcount of last sample
//   state         out  FSM state code
//   fault         out  high while in FAULT
//
// State   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a first event sample
// ARMING  | counting consecutive event samples toward CONFIRM_N
// IRRIGATE| valve open, on-time limits enforced
// COOLDOWN| valve closed, hold-off before re-arming is allowed
// FAULT   | sensor handshake timed out, waits for fault_clear
// -----------------------------------------------------------------------------
module irrigation_event_sequencer #(
    parameter int CNT_W         = 16,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CONFIRM_N     = 3,
    parameter int MIN_ON        = 500,
    parameter int MAX_ON        = 20000,
    parameter int COOLDOWN      = 2000,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] sensor_bits,
    input  logic       sensor_valid,
    input  logic       fault_clear,
    output logic       sample_req,
    output logic       valve_on,
    output logic       event_flag,
    output logic       any_flag,
    output logic [2:0] active_count,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMING   = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] ON_LAST     = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] ON_MIN      = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] CD_LOAD     = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [3:0]       CONFIRM_TGT = 4'(CONFIRM_N);

    function automatic logic [2:0] popcnt4(input logic [3:0] b);
        return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [3:0]       snap_q, snap_d;
    logic [3:0]       confirm_q, confirm_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;

    logic in_fault;
    logic tick;
    logic sample_done;
    logic wd_fire;
    logic event_now;

    // ------------------------------------------------------------------
    // Sample tick and request/acknowledge handshake
    // ------------------------------------------------------------------
    always_comb begin
        in_fault    = (state_q == ST_FAULT);
        tick        = enable && !in_fault && (tick_cnt_q == TICK_LAST);
        wd_fire     = req_q && !sensor_valid && (wd_cnt_q >= WD_LAST);
        sample_done = req_q && sensor_valid;
        // The FSM acts on the sample being captured this edge, so the event
        // decision looks at the live bus rather than the stored snapshot.
        event_now   = (popcnt4(sensor_bits) >= 3'd2);

        tick_cnt_d = tick_cnt_q;
        if (!enable || in_fault || tick) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q != CNT_MAX) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        // A tick that lands while a request is outstanding is dropped.
        req_d = req_q;
        if (in_fault || wd_fire) begin
            req_d = 1'b0;
        end else if (req_q) begin
            req_d = !sensor_valid;
        end else if (tick) begin
            req_d = 1'b1;
        end

        wd_cnt_d = '0;
        if (!in_fault && req_q && !sensor_valid && !wd_fire && (wd_cnt_q != CNT_MAX)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        snap_d = sample_done ? sensor_bits : snap_q;
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        on_cnt_d  = on_cnt_q;
        cd_cnt_d  = cd_cnt_q;

        if (wd_fire) begin
            // Handshake timeout wins over every other transition.
            state_d   = ST_FAULT;
            confirm_d = '0;
            on_cnt_d  = '0;
            cd_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    confirm_d = '0;
                    // A request that completes after enable dropped must not
                    // start a new arming run.
                    if (enable && sample_done && event_now) begin
                        confirm_d = 4'd1;
                        on_cnt_d  = '0;
                        state_d   = (CONFIRM_TGT <= 4'd1) ? ST_IRRIGATE : ST_ARMING;
                    end
                end

                ST_ARMING: begin
                    if (!enable) begin
                        state_d   = ST_IDLE;
                        confirm_d = '0;
                    end else if (sample_done) begin
                        if (event_now) begin
                            if ((confirm_q + 4'd1) >= CONFIRM_TGT) begin
                                confirm_d = CONFIRM_TGT;
                                on_cnt_d  = '0;
                                state_d   = ST_IRRIGATE;
                            end else begin
                                confirm_d = confirm_q + 4'd1;
                            end
                        end else begin
                            confirm_d = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                end

                ST_IRRIGATE: begin
                    // on_cnt_q == ON_LAST closes regardless of a same-cycle sample.
                    if ((on_cnt_q >= ON_LAST) || !enable ||
                        ((on_cnt_q >= ON_MIN) && sample_done && !event_now)) begin
                        state_d  = ST_COOLDOWN;
                        on_cnt_d = '0;
                        cd_cnt_d = CD_LOAD;
                    end else if (on_cnt_q != CNT_MAX) begin
                        on_cnt_d = on_cnt_q + 1'b1;
                    end
                end

                ST_COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        confirm_d = '0;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 1'b1;
                    end
                end

                ST_FAULT: begin
                    confirm_d = '0;
                    on_cnt_d  = '0;
                    cd_cnt_d  = '0;
                    if (fault_clear) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    confirm_d = '0;
                    on_cnt_d  = '0;
                    cd_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            req_q      <= 1'b0;
            wd_cnt_q   <= '0;
            snap_q     <= 4'b0000;
            confirm_q  <= '0;
            on_cnt_q   <= '0;
            cd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            req_q      <= req_d;
            wd_cnt_q   <= wd_cnt_d;
            snap_q     <= snap_d;
            confirm_q  <= confirm_d;
            on_cnt_q   <= on_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
        end
    end

    // Valve follows the state register directly so reset closes it at once.
    assign sample_req   = req_q;
    assign valve_on     = (state_q == ST_IRRIGATE);
    assign fault        = (state_q == ST_FAULT);
    assign state        = state_q;
    assign active_count = popcnt4(snap_q);
    assign event_flag   = (active_count >= 3'd2);
    assign any_flag     = |snap_q;

endmodule

// File: tb/tb_irrigation_event_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irrigation_event_sequencer
//
// Directed bench for irrigation_event_sequencer with shortened timing
// parameters. The sensor front-end acknowledges each request two cycles
// after it is seen, except where the watchdog is exercised.
// -----------------------------------------------------------------------------
module tb_irrigation_event_sequencer;

    localparam int SP    = 20;
    localparam int CN    = 3;
    localparam int MINON = 100;
    localparam int MAXON = 300;
    localparam int CD    = 40;
    localparam int ACK   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] sensor_bits = 4'b0000;
    logic       sensor_valid = 1'b0;
    logic       fault_clear = 1'b0;
    logic       sample_req;
    logic       valve_on;
    logic       event_flag;
    logic       any_flag;
    logic [2:0] active_count;
    logic [2:0] state;
    logic       fault;

    int total = 0;
    int bad   = 0;

    irrigation_event_sequencer #(
        .CNT_W        (16),
        .SAMPLE_PERIOD(SP),
        .CONFIRM_N    (CN),
        .MIN_ON       (MINON),
        .MAX_ON       (MAXON),
        .COOLDOWN     (CD),
        .ACK_TIMEOUT  (ACK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sensor_bits  (sensor_bits),
        .sensor_valid (sensor_valid),
        .fault_clear  (fault_clear),
        .sample_req   (sample_req),
        .valve_on     (valve_on),
        .event_flag   (event_flag),
        .any_flag     (any_flag),
        .active_count (active_count),
        .state        (state),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!sample_req && n < 100) begin
            tick_n(1);
            n++;
        end
        chk("req_wait", 32'(sample_req), 32'd1);
    endtask

    // Ack two cycles after the request is seen; returns just after the
    // capturing edge.
    task automatic do_sample(input logic [3:0] b);
        wait_req();
        tick_n(2);
        sensor_bits  = b;
        sensor_valid = 1'b1;
        tick_n(1);
        sensor_valid = 1'b0;
    endtask

    initial begin
        // Reset
        tick_n(3);
        chk("rst_req",   32'(sample_req),   32'd0);
        chk("rst_valve", 32'(valve_on),     32'd0);
        chk("rst_event", 32'(event_flag),   32'd0);
        chk("rst_any",   32'(any_flag),     32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        chk("rst_state", 32'(state),        32'd0);
        chk("rst_fault", 32'(fault),        32'd0);
        rst_n = 1'b1;
        tick_n(2);
        enable = 1'b1;

        // First request appears SP cycles after enable
        tick_n(SP - 1);
        chk("pre_tick_req",   32'(sample_req), 32'd0);
        chk("pre_tick_state", 32'(state),      32'd0);
        tick_n(1);
        chk("first_req", 32'(sample_req), 32'd1);

        // Three event samples open the valve
        do_sample(4'b0011);
        chk("arm1_state", 32'(state),        32'd1);
        chk("arm1_event", 32'(event_flag),   32'd1);
        chk("arm1_count", 32'(active_count), 32'd2);
        chk("arm1_req",   32'(sample_req),   32'd0);
        do_sample(4'b0011);
        chk("arm2_state", 32'(state),    32'd1);
        chk("arm2_valve", 32'(valve_on), 32'd0);
        do_sample(4'b0011);
        chk("open_state", 32'(state),    32'd2);
        chk("open_valve", 32'(valve_on), 32'd1);

        // Clear samples at on_cnt 19,39,59,79,99 hold; 119 closes
        for (int i = 0; i < 5; i++) begin
            do_sample(4'b0000);
            chk("minon_hold_valve", 32'(valve_on), 32'd1);
        end
        chk("minon_event_clear", 32'(event_flag), 32'd0);
        do_sample(4'b0000);
        chk("minon_close_state", 32'(state),    32'd3);
        chk("minon_close_valve", 32'(valve_on), 32'd0);

        // Samples during cooldown update flags only; cooldown lasts CD cycles
        do_sample(4'b1000);
        chk("cd_sample_state", 32'(state),        32'd3);
        chk("cd_sample_event", 32'(event_flag),   32'd0);
        chk("cd_sample_any",   32'(any_flag),     32'd1);
        chk("cd_sample_count", 32'(active_count), 32'd1);
        tick_n(CD - 21);
        chk("cd_last_state", 32'(state), 32'd3);
        tick_n(1);
        chk("cd_done_state", 32'(state), 32'd0);

        // Single-bit sample is not an event
        do_sample(4'b1000);
        chk("single_state", 32'(state),        32'd0);
        chk("single_event", 32'(event_flag),   32'd0);
        chk("single_any",   32'(any_flag),     32'd1);
        chk("single_count", 32'(active_count), 32'd1);

        // Non-event sample while arming resets the confirm count
        do_sample(4'b0011);
        do_sample(4'b0011);
        chk("abort_pre_state", 32'(state), 32'd1);
        do_sample(4'b0001);
        chk("abort_state", 32'(state),        32'd0);
        chk("abort_event", 32'(event_flag),   32'd0);
        chk("abort_count", 32'(active_count), 32'd1);
        do_sample(4'b0011);
        chk("rearm1_state", 32'(state), 32'd1);
        do_sample(4'b0011);
        chk("rearm2_state", 32'(state),    32'd1);
        chk("rearm2_valve", 32'(valve_on), 32'd0);
        do_sample(4'b0000);
        chk("rearm_idle_state", 32'(state),    32'd0);
        chk("rearm_idle_valve", 32'(valve_on), 32'd0);

        // Event held throughout: valve closes at on_cnt == MAX_ON-1 (299),
        // which coincides with the 15th sample capture.
        do_sample(4'b1100);
        do_sample(4'b1100);
        do_sample(4'b1100);
        chk("max_open_state", 32'(state), 32'd2);
        for (int i = 0; i < 14; i++) begin
            do_sample(4'b1111);
            chk("max_hold_valve", 32'(valve_on), 32'd1);
        end
        chk("max_hold_count", 32'(active_count), 32'd4);
        do_sample(4'b0111);
        chk("max_close_state", 32'(state),        32'd3);
        chk("max_close_valve", 32'(valve_on),     32'd0);
        chk("max_close_count", 32'(active_count), 32'd3);
        do_sample(4'b0000);
        tick_n(CD - 21);
        chk("max_cd_last", 32'(state), 32'd3);
        tick_n(1);
        chk("max_cd_done", 32'(state), 32'd0);

        // Watchdog during irrigation
        do_sample(4'b0011);
        do_sample(4'b0011);
        do_sample(4'b0011);
        chk("wd_open_state", 32'(state), 32'd2);
        wait_req();
        tick_n(ACK - 1);
        chk("wd_pre_fault", 32'(fault),      32'd0);
        chk("wd_pre_valve", 32'(valve_on),   32'd1);
        chk("wd_pre_req",   32'(sample_req), 32'd1);
        tick_n(1);
        chk("wd_fault", 32'(fault),      32'd1);
        chk("wd_state", 32'(state),      32'd4);
        chk("wd_valve", 32'(valve_on),   32'd0);
        chk("wd_req",   32'(sample_req), 32'd0);
        tick_n(30);
        chk("fault_hold_req",   32'(sample_req), 32'd0);
        chk("fault_hold_state", 32'(state),      32'd4);
        fault_clear = 1'b1;
        tick_n(1);
        fault_clear = 1'b0;
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_fault", 32'(fault), 32'd0);
        tick_n(SP - 1);
        chk("clear_pre_req", 32'(sample_req), 32'd0);
        tick_n(1);
        chk("clear_req", 32'(sample_req), 32'd1);

        // Asynchronous reset mid-irrigation
        do_sample(4'b0011);
        do_sample(4'b0011);
        do_sample(4'b0011);
        chk("arst_open_state", 32'(state), 32'd2);
        tick_n(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valve", 32'(valve_on),   32'd0);
        chk("arst_state", 32'(state),      32'd0);
        chk("arst_req",   32'(sample_req), 32'd0);
        tick_n(2);
        rst_n = 1'b1;
        tick_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
